bus_arbiter_rr: RTL

- Round-robin arbiter for the shared single-master-at-a-time system bus. The requesters are CI DMA engines, the CPU bus interface and camera/display masters.
- Samples per-master request lines and issues a one-cycle grant pulse to exactly one master.
- Tracks that master's transaction from begin-transaction through end-transaction, then re-arbitrates.
- Sits between the masters' request/grant pins and the bus, and is the only source of grant signals.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/rr_select.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin system bus arbiter.
package bus_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int OWNER_W     = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BEGIN = 2'd1,
    OWN        = 2'd2,
    RELEASE    = 2'd3
  } arbState_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester found searching upward
// from (pointer + 1) with wrap modulo NUM_MASTERS.
module rr_select
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] i_request,
  input  logic [OWNER_W-1:0]     i_pointer,
  output logic [OWNER_W-1:0]     o_sel,
  output logic                   o_valid
);

  logic [MAX_MASTERS-1:0] w_reqPad;

  assign w_reqPad = MAX_MASTERS'(i_request);

  // Walk the distances from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    o_sel   = '0;
    o_valid = 1'b0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = {1'b0, i_pointer} + 4'(i);
      if (idx >= 4'(NUM_MASTERS)) begin
        idx = idx - 4'(NUM_MASTERS);
      end
      if (w_reqPad[idx[2:0]]) begin
        o_sel   = idx[2:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin single-owner bus arbiter with begin/end transaction tracking.
// Optional ownership watchdog enabled by defining BUS_ARB_XFER_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int XFER_TIMEOUT  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   in_busBeginTransaction,
  input  logic                   in_busEndTransaction,
  input  logic                   in_busError,
  output logic [OWNER_W-1:0]     owner,
  output logic                   busActive,
  output logic                   out_busError,
  output logic                   out_busEndTransaction
);

  localparam int MAX_TIMEOUT = (BEGIN_TIMEOUT > XFER_TIMEOUT) ? BEGIN_TIMEOUT : XFER_TIMEOUT;
  localparam int CNT_W       = $clog2(MAX_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arbState_t              r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [OWNER_W-1:0]     r_owner;
  logic                   r_busActive;
  logic [CNT_W-1:0]       r_count;
  logic [OWNER_W-1:0]     w_sel;
  logic                   w_valid;

  rr_select #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rrSelect (
    .i_request(request),
    .i_pointer(r_owner),
    .o_sel    (w_sel),
    .o_valid  (w_valid)
  );

`ifdef BUS_ARB_XFER_TIMEOUT_EN
  logic r_busError;
  logic r_busEnd;

  assign out_busError          = r_busError;
  assign out_busEndTransaction = r_busEnd;
`else
  assign out_busError          = 1'b0;
  assign out_busEndTransaction = 1'b0;
`endif

  // One counter serves both the begin timeout and the ownership watchdog,
  // since the two waiting states never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= OWNER_W'(NUM_MASTERS - 1);
      r_busActive <= 1'b0;
      r_count     <= '0;
`ifdef BUS_ARB_XFER_TIMEOUT_EN
      r_busError  <= 1'b0;
      r_busEnd    <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
`ifdef BUS_ARB_XFER_TIMEOUT_EN
      r_busError <= 1'b0;
      r_busEnd   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant     <= NUM_MASTERS'(1) << w_sel;
            r_owner     <= w_sel;
            r_busActive <= 1'b1;
            r_count     <= '0;
            r_state     <= WAIT_BEGIN;
          end
        end
        WAIT_BEGIN: begin
          if (in_busBeginTransaction && in_busEndTransaction) begin
            r_state <= RELEASE;
          end else if (in_busBeginTransaction) begin
            r_count <= '0;
            r_state <= OWN;
          end else if (r_count == CNT_W'(BEGIN_TIMEOUT - 1)) begin
            // Owner is kept so the silent master drops to lowest priority.
            r_busActive <= 1'b0;
            r_state     <= IDLE;
          end else if (r_count != CNT_MAX) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        OWN: begin
`ifdef BUS_ARB_XFER_TIMEOUT_EN
          // The abort pulse occupies the last owned cycle, like a real end.
          if (in_busEndTransaction || in_busError || r_busEnd) begin
            r_state <= RELEASE;
          end else if (r_count == CNT_W'(XFER_TIMEOUT - 2)) begin
            r_busError <= 1'b1;
            r_busEnd   <= 1'b1;
          end else if (r_count != CNT_MAX) begin
            r_count <= r_count + CNT_W'(1);
          end
`else
          if (in_busEndTransaction || in_busError) begin
            r_state <= RELEASE;
          end
`endif
        end
        RELEASE: begin
          r_busActive <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign busActive = r_busActive;

endmodule
